// File: rtl/mgmt_gpio_in_sampler.sv
// Samples the asynchronous management GPIO inputs: 2-flop synchroniser, per-bit debounce,
// programmable edge detection and sticky pending flags feeding one level interrupt.
module mgmt_gpio_in_sampler #(
  parameter int NPADS = 19,
  parameter int DBW   = 4
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [NPADS-1:0] mgmt_gpio_in_buf,
  input  logic [NPADS-1:0] rise_en,
  input  logic [NPADS-1:0] fall_en,
  input  logic [NPADS-1:0] irq_mask,
  input  logic [DBW-1:0]   debounce_limit,
  input  logic             clr_valid,
  input  logic [NPADS-1:0] clr_mask,
  output logic [NPADS-1:0] gpio_state,
  output logic [NPADS-1:0] pending,
  output logic             irq,
  output logic             ready
);

  typedef enum logic [1:0] {FILL0, FILL1, LOAD, RUN} state_t;

  state_t state, state_nxt;
  logic   load_en, run_en;

  logic [NPADS-1:0] s1, s2;
  logic [DBW-1:0]   cnt     [NPADS];
  logic [DBW-1:0]   cnt_nxt [NPADS];
  logic [NPADS-1:0] commit;
  logic [NPADS-1:0] rise_ev, fall_ev;
  logic [NPADS-1:0] gpio_nxt, pending_nxt;

  // Returns {commit, next count}; the >= compare lets a lowered limit commit at once.
  function automatic logic [DBW:0] db_step(input logic differ,
                                           input logic [DBW-1:0] c,
                                           input logic [DBW-1:0] lim);
    if (!differ) return '0;
    if (c >= lim) return {1'b1, {DBW{1'b0}}};
    return {1'b0, c + DBW'(1)};
  endfunction

  always_ff @(posedge clk) begin
    if (!resetn) state <= FILL0;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      FILL0:   state_nxt = FILL1;
      FILL1:   state_nxt = LOAD;
      LOAD:    state_nxt = RUN;
      RUN:     state_nxt = RUN;
      default: state_nxt = FILL0;
    endcase
  end

  always_comb begin
    load_en = (state == LOAD);
    run_en  = (state == RUN);
    ready   = run_en;
  end

  always_comb begin
    for (int i = 0; i < NPADS; i++) begin
      {commit[i], cnt_nxt[i]} = run_en ? db_step(s2[i] != gpio_state[i], cnt[i], debounce_limit)
                                       : '0;
    end
    rise_ev     = commit & s2 & rise_en;
    fall_ev     = commit & ~s2 & fall_en;
    gpio_nxt    = load_en ? s2 : ((gpio_state & ~commit) | (s2 & commit));
    pending_nxt = (pending & ~(clr_valid ? clr_mask : '0)) | rise_ev | fall_ev;
  end

  // Stage p0/p1: synchroniser; then debounce state and sticky flags.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      s1         <= '0;
      s2         <= '0;
      gpio_state <= '0;
      pending    <= '0;
      for (int i = 0; i < NPADS; i++) cnt[i] <= '0;
    end else begin
      s1         <= mgmt_gpio_in_buf;
      s2         <= s1;
      gpio_state <= gpio_nxt;
      pending    <= pending_nxt;
      for (int i = 0; i < NPADS; i++) cnt[i] <= cnt_nxt[i];
    end
  end

  assign irq = |(pending & irq_mask);

endmodule

// File: tb/tb_mgmt_gpio_in_sampler.sv
// Directed and randomized bench for mgmt_gpio_in_sampler with an edge-by-edge reference model.
module tb_mgmt_gpio_in_sampler;
  localparam int NPADS = 19;
  localparam int DBW   = 4;

  logic             clk = 1'b0;
  logic             resetn;
  logic [NPADS-1:0] pad;
  logic [NPADS-1:0] rise_en, fall_en, irq_mask, clr_mask;
  logic [DBW-1:0]   debounce_limit;
  logic             clr_valid;
  logic [NPADS-1:0] gpio_state, pending;
  logic             irq, ready;

  int checks   = 0;
  int failures = 0;

  // Reference model: pad history, committed level, sticky flags, start-up phase.
  logic [NPADS-1:0] m_s1 = '0, m_s2 = '0, m_state = '0, m_pend = '0;
  int               m_run [NPADS];
  int               m_phase = 0;

  mgmt_gpio_in_sampler #(.NPADS(NPADS), .DBW(DBW)) dut (
    .clk(clk), .resetn(resetn), .mgmt_gpio_in_buf(pad),
    .rise_en(rise_en), .fall_en(fall_en), .irq_mask(irq_mask),
    .debounce_limit(debounce_limit), .clr_valid(clr_valid), .clr_mask(clr_mask),
    .gpio_state(gpio_state), .pending(pending), .irq(irq), .ready(ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance the model by one rising edge using the inputs currently applied.
  task automatic model_edge();
    logic [NPADS-1:0] ev;
    ev = '0;
    if (!resetn) begin
      m_s1 = '0; m_s2 = '0; m_state = '0; m_pend = '0; m_phase = 0;
      for (int i = 0; i < NPADS; i++) m_run[i] = 0;
    end else begin
      if (m_phase == 3) begin
        for (int i = 0; i < NPADS; i++) begin
          if (m_s2[i] == m_state[i]) m_run[i] = 0;
          else if (m_run[i] >= int'(debounce_limit)) begin
            m_state[i] = m_s2[i];
            m_run[i]   = 0;
            ev[i] = m_s2[i] ? rise_en[i] : fall_en[i];
          end else m_run[i]++;
        end
      end else if (m_phase == 2) begin
        m_state = m_s2;
        for (int i = 0; i < NPADS; i++) m_run[i] = 0;
      end
      m_pend  = (m_pend & ~(clr_valid ? clr_mask : '0)) | ev;
      m_phase = (m_phase < 3) ? m_phase + 1 : 3;
      m_s2 = m_s1;
      m_s1 = pad;
    end
  endtask

  task automatic check_all();
    chk("gpio_state", 32'(gpio_state), 32'(m_state));
    chk("pending", 32'(pending), 32'(m_pend));
    chk("irq", 32'(irq), 32'(|(m_pend & irq_mask)));
    chk("ready", 32'(ready), 32'(m_phase == 3));
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    check_all();
  endtask

  initial begin
    for (int i = 0; i < NPADS; i++) m_run[i] = 0;
    resetn = 1'b0; pad = 19'h7FFFF; rise_en = '0; fall_en = '0; irq_mask = '1;
    clr_mask = '0; clr_valid = 1'b0; debounce_limit = '0;

    // 1: reset and release with all pads high
    step(); step();
    chk("t1_rst_ready", 32'(ready), 0);
    chk("t1_rst_state", 32'(gpio_state), 0);
    resetn = 1'b1;
    step(); chk("t1_e1_ready", 32'(ready), 0);
    step(); chk("t1_e2_ready", 32'(ready), 0);
    step(); chk("t1_e3_ready", 32'(ready), 1);
    chk("t1_state", 32'(gpio_state), 32'h7FFFF);
    chk("t1_pending", 32'(pending), 0);

    // 2: limit 0, rising edge on pad 5
    pad = '0;
    repeat (4) step();
    rise_en = 19'(1) << 5; irq_mask = 19'(1) << 5; pad[5] = 1'b1;
    step(); step();
    chk("t2_e2_state5", 32'(gpio_state[5]), 0);
    step();
    chk("t2_e3_state5", 32'(gpio_state[5]), 1);
    chk("t2_e3_pend5", 32'(pending[5]), 1);
    chk("t2_e3_irq", 32'(irq), 1);
    clr_valid = 1'b1; clr_mask = '1;
    step();
    clr_valid = 1'b0;

    // 3: limit 3, short glitch then a real pulse on pad 2
    debounce_limit = 4'd3; rise_en = 19'(1) << 2; fall_en = 19'(1) << 2;
    for (int k = 1; k <= 10; k++) begin
      pad[2] = (k <= 3);
      step();
    end
    chk("t3_glitch_state2", 32'(gpio_state[2]), 0);
    chk("t3_glitch_pend2", 32'(pending[2]), 0);
    clr_mask = 19'(1) << 2;
    for (int k = 1; k <= 12; k++) begin
      pad[2] = (k <= 5);
      clr_valid = (k == 7);
      step();
      if (k == 5) chk("t3_e5_state2", 32'(gpio_state[2]), 0);
      if (k == 6) begin
        chk("t3_e6_state2", 32'(gpio_state[2]), 1);
        chk("t3_e6_pend2", 32'(pending[2]), 1);
      end
      if (k == 10) begin
        chk("t3_f5_state2", 32'(gpio_state[2]), 1);
        chk("t3_f5_pend2", 32'(pending[2]), 0);
      end
      if (k == 11) begin
        chk("t3_f6_state2", 32'(gpio_state[2]), 0);
        chk("t3_f6_pend2", 32'(pending[2]), 1);
      end
    end
    clr_valid = 1'b0;

    // 4: clear and new event on bit 7 in the same cycle
    debounce_limit = '0; rise_en = 19'(1) << 7; fall_en = 19'(1) << 7; irq_mask = 19'(1) << 7;
    pad[7] = 1'b1; repeat (3) step();
    chk("t4_pend7_set", 32'(pending[7]), 1);
    pad[7] = 1'b0; repeat (3) step();
    pad[7] = 1'b1; step(); step();
    clr_valid = 1'b1; clr_mask = 19'(1) << 7;
    step();
    chk("t4_setwins_pend7", 32'(pending[7]), 1);
    chk("t4_setwins_irq", 32'(irq), 1);
    step();
    chk("t4_clear_pend7", 32'(pending[7]), 0);
    chk("t4_clear_irq", 32'(irq), 0);
    clr_mask = '1; step();
    clr_valid = 1'b0;

    // 5: mask toggling on a pending bit 0
    rise_en = 19'(1) << 0; fall_en = '0; pad[0] = 1'b1;
    repeat (3) step();
    chk("t5_pend0", 32'(pending[0]), 1);
    irq_mask = 19'(1); #1 chk("t5_irq_on", 32'(irq), 1);
    irq_mask = '0;     #1 chk("t5_irq_off", 32'(irq), 0);
    irq_mask = 19'(1); #1 chk("t5_irq_on2", 32'(irq), 1);
    chk("t5_pend0_kept", 32'(pending[0]), 1);

    // 6: reset in the middle of a debounce
    debounce_limit = 4'd7; rise_en = 19'(1) << 4; pad[4] = 1'b1;
    repeat (4) step();
    chk("t6_pre_state4", 32'(gpio_state[4]), 0);
    resetn = 1'b0;
    step();
    chk("t6_rst_state", 32'(gpio_state), 0);
    chk("t6_rst_pend", 32'(pending), 0);
    chk("t6_rst_ready", 32'(ready), 0);
    chk("t6_rst_irq", 32'(irq), 0);
    resetn = 1'b1;
    step(); chk("t6_e1_ready", 32'(ready), 0);
    step(); chk("t6_e2_ready", 32'(ready), 0);
    step(); chk("t6_e3_ready", 32'(ready), 1);
    chk("t6_no_spurious", 32'(pending), 0);
    chk("t6_loaded", 32'(gpio_state), 32'(pad));

    // Randomized traffic against the model
    for (int n = 0; n < 600; n++) begin
      resetn = ($urandom_range(0, 149) != 0);
      for (int i = 0; i < NPADS; i++) if ($urandom_range(0, 5) == 0) pad[i] = ~pad[i];
      if ($urandom_range(0, 31) == 0) debounce_limit = DBW'($urandom_range(0, 4));
      if ($urandom_range(0, 15) == 0) begin
        rise_en = NPADS'($urandom); fall_en = NPADS'($urandom); irq_mask = NPADS'($urandom);
      end
      clr_valid = ($urandom_range(0, 3) == 0);
      clr_mask  = NPADS'($urandom);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mgmt_gpio_in_sampler.md
Name: mgmt_gpio_in_sampler

Overview:
- Consumes the buffered management GPIO inputs (mgmt_gpio_in_buf) in the management clock domain, which is the reader end of the pad-to-management input path.
- Per bit: 2-flop synchroniser, debounce filter, programmable edge detect, and sticky pending flags.
- Drives one level interrupt to the management core.
- A small start-up FSM suppresses spurious edges after reset.

Parameters:
- NPADS, 19, number of management GPIO input bits sampled (matches MPRJ_IO_PADS_1).
- DBW, 4, width of the per-bit debounce counter and of debounce_limit.

Ports:
- clk  input  1  management clock.
- resetn  input  1  synchronous, active-low reset.
- mgmt_gpio_in_buf  input  NPADS  asynchronous buffered pad inputs.
- rise_en  input  NPADS  per-bit enable for rising-edge events.
- fall_en  input  NPADS  per-bit enable for falling-edge events.
- irq_mask  input  NPADS  per-bit interrupt enable.
- debounce_limit  input  DBW  stable cycles required beyond the first; 0 means no filtering.
- clr_valid  input  1  single-cycle strobe that clears the pending bits selected by clr_mask.
- clr_mask  input  NPADS  write-one-to-clear mask, sampled only when clr_valid=1.
- gpio_state  output  NPADS  debounced, synchronised input values.
- pending  output  NPADS  sticky edge-event flags.
- irq  output  1  |(pending & irq_mask), combinational from registers.
- ready  output  1  high when the FSM is in RUN.

Behaviour:
- Reset is synchronous and active-low: every flop updates only on the clk rising edge while resetn=0.
- Reset values:
  - s1, s2, gpio_state, all counters and pending are 0.
  - irq is 0 and ready is 0.
  - FSM is in FILL0.
- Synchroniser runs every cycle, including during reset release: s1<=mgmt_gpio_in_buf, then s2<=s1.
- FSM:
  - FILL0->FILL1->LOAD->RUN, one cycle each, starting at the first edge with resetn=1.
  - In LOAD: gpio_state<=s2, counters<=0, no events, pending unchanged (stays 0).
  - RUN is terminal until reset.
  - resetn=0 in any state returns to FILL0 and clears all state on that edge.
- Debounce, per bit i, RUN only:
  - If s2[i]==gpio_state[i]: cnt[i]<=0.
  - Else if cnt[i]>=debounce_limit: commit, i.e. gpio_state[i]<=s2[i] and cnt[i]<=0.
  - Else cnt[i]<=cnt[i]+1.
  - The counter never wraps: with the >= compare it saturates at the limit.
  - debounce_limit may change at any time. The current value is used, so a cnt already above a lowered limit commits on the next edge.
- Latency, pad change to gpio_state: 3+L rising edges, where L=debounce_limit and the pad is held stable throughout.
- Glitch filtering: a pulse shorter than L+1 cycles at s2 never commits.
- Events:
  - Generated only on a commit edge.
  - rise_ev[i] = commit & s2[i] & rise_en[i].
  - fall_ev[i] = commit & ~s2[i] & fall_en[i].
  - Enables are sampled on the commit edge.
- Pending update each edge:
  - pending <= (pending & ~(clr_valid ? clr_mask : 0)) | rise_ev | fall_ev.
  - An event and a clear on the same bit in the same cycle leaves the bit SET (set wins).
  - Clearing bits with no event is idempotent.
  - Disabling rise_en/fall_en does not clear existing pending bits.
- irq tracks pending and irq_mask with no added register stage. Masking a bit drops irq in the same cycle if no other masked-in bit is pending.
- Before RUN, clr_valid is accepted but has no visible effect, since pending is already 0.

Test Plan:
1. Reset release with mgmt_gpio_in_buf=19'h7FFFF:
   - ready=1 after edge 3.
   - gpio_state=7FFFF.
   - pending=0 and irq=0 throughout.
2. debounce_limit=0, rise_en[5]=1, irq_mask[5]=1, in RUN, pad[5] 0->1:
   - gpio_state[5]=1 and pending[5]=1 after exactly 3 edges.
   - irq=1 in the same cycle.
3. debounce_limit=3, pad[2] pulses high for 3 cycles, then again for 5 cycles, fall_en[2]=rise_en[2]=1:
   - First pulse causes no state change and no pending.
   - Second pulse commits on edge 6 after the pad change.
   - Fall event follows the trailing edge, with the same 6-edge latency.
4. Simultaneous clear and new event on bit 7 (clr_valid=1, clr_mask[7]=1, commit rising on that edge):
   - pending[7] stays 1.
   - On a subsequent clear with no event, pending[7]=0 and irq drops the same cycle.
5. pending[0]=1 with irq_mask[0] toggled 1->0->1:
   - irq follows 1->0->1 combinationally.
   - pending[0] remains 1.
6. Reset asserted mid-debounce (cnt[4]=2):
   - Next edge: all outputs 0, ready=0.
   - Upon release the FSM re-walks FILL0/FILL1/LOAD with no spurious event.
